// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state type for the binary-to-BCD display formatter
package bcd_pkg;

    localparam int          DIGITS  = 8;
    localparam int          BCD_W   = 32;
    localparam logic [31:0] BCD_MAX = 32'd99_999_999;
    localparam logic [31:0] BCD_OVF = 32'h9999_9999;

    typedef enum logic {
        IDLE,
        CONV
    } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble digit correction: add 3 to a BCD digit that is 5 or more
module bcd_digit_adjust (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    always_comb begin
        d_out = d_in;
        if (d_in >= 4'd5) begin
            d_out = d_in + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_display_formatter.sv
// rtl/bcd_display_formatter.sv - iterative binary-to-packed-BCD converter feeding the 7-seg controller
// Optional accept-rate throttle enabled by defining BCD_THROTTLE_EN.
import bcd_pkg::*;

module bcd_display_formatter #(
    parameter int BIN_W         = 27,
    parameter int UPDATE_PERIOD = 10_000_000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [31:0]      bcd_out,
    output logic             bcd_valid_out,
    output logic             overflow_out
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    bcd_state_t             state_q, state_d;
    logic [BIN_W-1:0]       shift_q, shift_d;
    logic [BCD_W-1:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   bcd_valid_q, bcd_valid_d;
    logic                   ovf_q, ovf_d;
    logic                   ovf_pend_q, ovf_pend_d;

    logic [BCD_W-1:0]       adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [32:0]            bin_ext;
    logic                   accept;
    logic                   idle;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_adj
            bcd_digit_adjust u_adj (
                .d_in  (scratch_q[4*i +: 4]),
                .d_out (adj[4*i +: 4])
            );
        end
    endgenerate

    // One double-dabble iteration: corrected digits and remaining binary bits shift left together.
    assign shifted = {adj, shift_q} << 1;
    assign bin_ext = 33'(bin_in);
    assign idle    = (state_q == IDLE);
    assign accept  = valid_in && ready_out;

`ifdef BCD_THROTTLE_EN
    localparam int               THR_W     = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [THR_W-1:0] THR_READY = THR_W'(UPDATE_PERIOD - 1);

    logic [THR_W-1:0] thr_q, thr_d;

    assign ready_out = idle && (thr_q >= THR_READY);

    always_comb begin
        thr_d = thr_q;
        if (accept) begin
            thr_d = '0;
        end else if (thr_q < THR_READY) begin
            thr_d = thr_q + 1'b1;
        end
    end

    // Reset lands on the ready value so the first post-reset sample is not delayed.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            thr_q <= THR_READY;
        end else begin
            thr_q <= thr_d;
        end
    end
`else
    assign ready_out = idle;
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        ovf_d       = ovf_q;
        ovf_pend_d  = ovf_pend_q;

        if (state_q == IDLE) begin
            if (accept) begin
                shift_d    = bin_in;
                scratch_d  = '0;
                cnt_d      = CNT_W'(BIN_W);
                ovf_pend_d = (bin_ext > 33'(BCD_MAX));
                state_d    = CONV;
            end
        end else begin
            scratch_d = shifted[BIN_W +: BCD_W];
            shift_d   = shifted[BIN_W-1:0];
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d     = IDLE;
                bcd_d       = ovf_pend_q ? BCD_OVF : shifted[BIN_W +: BCD_W];
                ovf_d       = ovf_pend_q;
                bcd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            ovf_q       <= ovf_d;
            ovf_pend_q  <= ovf_pend_d;
        end
    end

    assign bcd_out       = bcd_q;
    assign bcd_valid_out = bcd_valid_q;
    assign overflow_out  = ovf_q;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// tb/tb_bcd_display_formatter.sv - self-checking bench for bcd_display_formatter against a div/mod reference
module tb_bcd_display_formatter;

    localparam int BIN_W = 27;
    localparam int UPD   = 100;
`ifdef BCD_THROTTLE_EN
    localparam int SPACING = (UPD > BIN_W + 1) ? UPD : BIN_W + 1;
`else
    localparam int SPACING = BIN_W + 1;
`endif

    logic             clk = 1'b0;
    logic             rst_in;
    logic [BIN_W-1:0] bin_in;
    logic             valid_in;
    logic             ready_out;
    logic [31:0]      bcd_out;
    logic             bcd_valid_out;
    logic             overflow_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_q[$];

    bcd_display_formatter #(
        .BIN_W         (BIN_W),
        .UPDATE_PERIOD (UPD)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .bin_in        (bin_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .bcd_out       (bcd_out),
        .bcd_valid_out (bcd_valid_out),
        .overflow_out  (overflow_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record the number of each edge at which a sample will be accepted.
    always @(negedge clk) begin
        if (valid_in && ready_out && !rst_in) acc_q.push_back(cyc + 1);
    end

    function automatic logic [31:0] ref_bcd(input longint v);
        logic [31:0] r;
        longint      t;
        r = '0;
        t = v;
        if (v > 64'd99_999_999) return 32'h9999_9999;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input longint v, output int lat);
        int n;
        n = 0;
        bin_in   = BIN_W'(v);
        valid_in = 1'b1;
        while (!ready_out && n < 500) begin
            step();
            n++;
        end
        step();
        valid_in = 1'b0;
        lat = 0;
        while (!bcd_valid_out && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        bin_in   = '0;
        step();
        step();
        rst_in = 1'b0;
        total++; if (bcd_out !== 32'h0) begin bad++; $display("FAIL reset_bcd: got %h want %h", bcd_out, 32'h0); end
        total++; if (bcd_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bcd_valid_out); end
        total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow_out); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_out); end
    endtask

    task automatic test_zero();
        int lat;
        convert(0, lat);
        total++; if (lat !== BIN_W) begin bad++; $display("FAIL zero_latency: got %0d want %0d", lat, BIN_W); end
        total++; if (bcd_out !== 32'h0) begin bad++; $display("FAIL zero_bcd: got %h want %h", bcd_out, 32'h0); end
        total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL zero_ovf: got %b want 0", overflow_out); end
        step();
        total++; if (bcd_valid_out !== 1'b0) begin bad++; $display("FAIL zero_pulse_width: got %b want 0", bcd_valid_out); end
    endtask

    task automatic test_known();
        int lat;
        convert(12_345_678, lat);
        total++; if (lat !== BIN_W) begin bad++; $display("FAIL known_latency: got %0d want %0d", lat, BIN_W); end
        total++; if (bcd_out !== 32'h1234_5678) begin bad++; $display("FAIL known_bcd: got %h want %h", bcd_out, 32'h1234_5678); end
        total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL known_ovf: got %b want 0", overflow_out); end
    endtask

    task automatic test_boundary();
        int lat;
        convert(99_999_999, lat);
        total++; if (bcd_out !== 32'h9999_9999) begin bad++; $display("FAIL max_bcd: got %h want %h", bcd_out, 32'h9999_9999); end
        total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL max_ovf: got %b want 0", overflow_out); end
        convert(100_000_000, lat);
        total++; if (bcd_out !== 32'h9999_9999) begin bad++; $display("FAIL over_bcd: got %h want %h", bcd_out, 32'h9999_9999); end
        total++; if (overflow_out !== 1'b1) begin bad++; $display("FAIL over_ovf: got %b want 1", overflow_out); end
        total++; if (lat !== BIN_W) begin bad++; $display("FAIL over_latency: got %0d want %0d", lat, BIN_W); end
    endtask

    task automatic test_back_to_back();
        int n;
        acc_q.delete();
        bin_in   = BIN_W'(5);
        valid_in = 1'b1;
        n = 0;
        while (acc_q.size() < 1 && n < 500) begin step(); n++; end
        bin_in = BIN_W'(7);
        for (int i = 0; i < 10; i++) step();
        total++; if (bcd_out !== 32'h9999_9999 || overflow_out !== 1'b1) begin
            bad++; $display("FAIL hold_during_conv: got %h/%b want %h/1", bcd_out, overflow_out, 32'h9999_9999);
        end
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", ready_out); end
        n = 0;
        while (!bcd_valid_out && n < 200) begin step(); n++; end
        total++; if (bcd_out !== 32'h0000_0005 || overflow_out !== 1'b0) begin
            bad++; $display("FAIL first_of_pair: got %h/%b want %h/0", bcd_out, overflow_out, 32'h5);
        end
        n = 0;
        while (acc_q.size() < 2 && n < 500) begin step(); n++; end
        valid_in = 1'b0;
        n = 0;
        while (!bcd_valid_out && n < 200) begin step(); n++; end
        total++; if (bcd_out !== 32'h0000_0007) begin bad++; $display("FAIL second_of_pair: got %h want %h", bcd_out, 32'h7); end
        total++; if (acc_q.size() !== 2) begin bad++; $display("FAIL accept_count: got %0d want 2", acc_q.size()); end
        if (acc_q.size() >= 2) begin
            total++; if (acc_q[1] - acc_q[0] !== SPACING) begin
                bad++; $display("FAIL accept_spacing: got %0d want %0d", acc_q[1] - acc_q[0], SPACING);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        bin_in   = BIN_W'(42);
        valid_in = 1'b1;
        n = 0;
        while (!ready_out && n < 500) begin step(); n++; end
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        total++; if (bcd_out !== 32'h0) begin bad++; $display("FAIL midrst_bcd: got %h want %h", bcd_out, 32'h0); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", ready_out); end
        total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL midrst_ovf: got %b want 0", overflow_out); end
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (bcd_valid_out) pulses++;
            step();
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", pulses); end
        total++; if (bcd_out !== 32'h0) begin bad++; $display("FAIL midrst_discard: got %h want %h", bcd_out, 32'h0); end
    endtask

    task automatic test_random();
        int     lat;
        longint v;
        logic [31:0] exp_bcd;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0:       v = 99_999_998;
                1:       v = 100_000_001;
                2:       v = (1 << BIN_W) - 1;
                3:       v = 9;
                default: v = longint'($urandom_range((1 << BIN_W) - 1, 0));
            endcase
            exp_bcd = ref_bcd(v);
            convert(v, lat);
            total++; if (bcd_out !== exp_bcd) begin bad++; $display("FAIL rand_bcd[%0d] in=%0d: got %h want %h", i, v, bcd_out, exp_bcd); end
            total++; if (overflow_out !== (v > 99_999_999)) begin
                bad++; $display("FAIL rand_ovf[%0d] in=%0d: got %b want %b", i, v, overflow_out, (v > 99_999_999));
            end
            total++; if (lat !== BIN_W) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, BIN_W); end
        end
    endtask

`ifdef BCD_THROTTLE_EN
    task automatic test_throttle();
        int n;
        acc_q.delete();
        bin_in   = BIN_W'(123_456);
        valid_in = 1'b1;
        for (int i = 0; i < 350; i++) step();
        valid_in = 1'b0;
        n = 0;
        while (!bcd_valid_out && n < 200) begin step(); n++; end
        total++; if (acc_q.size() < 3) begin bad++; $display("FAIL throttle_count: got %0d want >=3", acc_q.size()); end
        for (int i = 1; i < acc_q.size(); i++) begin
            total++; if (acc_q[i] - acc_q[i-1] !== UPD) begin
                bad++; $display("FAIL throttle_spacing[%0d]: got %0d want %0d", i, acc_q[i] - acc_q[i-1], UPD);
            end
        end
        total++; if (bcd_out !== 32'h0012_3456) begin bad++; $display("FAIL throttle_bcd: got %h want %h", bcd_out, 32'h0012_3456); end
    endtask
`endif

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        bin_in   = '0;
        test_reset();
        test_zero();
        test_known();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef BCD_THROTTLE_EN
        test_throttle();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
